// File: rtl/mips_chk_pkg.sv
// Shared types for the retire checker: FSM states and the expected-trace entry.
package mips_chk_pkg;

   localparam int unsigned DEST_W     = 5;
   // Widest retire data the table can hold; narrower data is zero-extended on load and compare.
   localparam int unsigned MAX_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      TMO  = 2'd3
   } chk_state_e;

   typedef struct packed {
      logic [DEST_W-1:0]     dest;
      logic [MAX_DATA_W-1:0] data;
   } exp_entry_t;

   // An entry matches a retire only when both destination and value agree.
   function automatic logic entry_match(input exp_entry_t       e,
                                        input logic [DEST_W-1:0] dest,
                                        input logic [MAX_DATA_W-1:0] data);
      return (e.dest == dest) && (e.data == data);
   endfunction

endpackage

// File: rtl/mips_chk_ram.sv
// Expected-trace table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a trace survives a checker reset.
module mips_chk_ram
   import mips_chk_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  exp_entry_t    wdata,
   input  logic [AW-1:0] raddr,
   output exp_entry_t    rdata
);

   exp_entry_t mem_r [DEPTH];

   // Table write on the rising edge
   always_ff @(posedge clock) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/mips_retire_checker.sv
// Compares the retired-instruction stream of a MIPS core against a preloaded
// expected trace and reports pass/fail counts, the first mismatch and timeouts.
module mips_retire_checker
   import mips_chk_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned PC_W           = 32,
   parameter int unsigned DEPTH          = 64,
   parameter int unsigned TO_CYCLES      = 1024,
   parameter bit          SKIP_ZERO_DEST = 1'b1,
   parameter int unsigned CW             = $clog2(DEPTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load_we,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [4:0]               load_dest,
   input  logic [DATA_W-1:0]        load_data,
   input  logic                     start,
   input  logic [CW-1:0]            n_checks,
   input  logic                     retire_valid,
   input  logic [4:0]               retire_dest,
   input  logic [DATA_W-1:0]        retire_data,
   input  logic [PC_W-1:0]          retire_pc,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [CW-1:0]            pass_count,
   output logic [CW-1:0]            fail_count,
   output logic [CW-1:0]            first_fail_idx,
   output logic [PC_W-1:0]          first_fail_pc,
   output logic [DATA_W-1:0]        first_fail_data
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned TW        = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LIM = TW'(TO_CYCLES - 1);

   chk_state_e          state_r, state_nx_s;
   logic [CW-1:0]       n_r, n_nx_s, n_clamp_s, last_idx_s;
   logic [CW-1:0]       idx_r, idx_nx_s;
   logic [TW-1:0]       timer_r, timer_nx_s;
   logic [CW-1:0]       pass_count_r, pass_nx_s;
   logic [CW-1:0]       fail_count_r, fail_nx_s;
   logic [CW-1:0]       ff_idx_r, ff_idx_nx_s;
   logic [PC_W-1:0]     ff_pc_r, ff_pc_nx_s;
   logic [DATA_W-1:0]   ff_data_r, ff_data_nx_s;
   logic                busy_r, done_r, timeout_r;
   logic                load_ok_s, qual_s, match_s, skip_s;
   exp_entry_t          wr_entry_s, rd_entry_s;

   // The table only accepts writes while the checker is parked in IDLE.
   assign load_ok_s  = load_we && (state_r == IDLE);
   assign wr_entry_s = '{dest: load_dest, data: MAX_DATA_W'(load_data)};

   mips_chk_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock (clock),
      .we    (load_ok_s),
      .waddr (load_addr),
      .wdata (wr_entry_s),
      .raddr (idx_r[AW-1:0]),
      .rdata (rd_entry_s)
   );

   // Stores (SW) and branches retire with dest 0 and carry no writeback to check.
   assign skip_s     = SKIP_ZERO_DEST && (retire_dest == 5'd0);
   assign qual_s     = retire_valid && (state_r == RUN) && !skip_s;
   assign match_s    = entry_match(rd_entry_s, retire_dest, MAX_DATA_W'(retire_data));
   assign n_clamp_s  = (n_checks > DEPTH_C) ? DEPTH_C : n_checks;
   assign last_idx_s = n_r - CW'(1);

   // Next-state, run counters, timer and first-fail capture
   always_comb begin
      state_nx_s   = state_r;
      n_nx_s       = n_r;
      idx_nx_s     = idx_r;
      timer_nx_s   = timer_r;
      pass_nx_s    = pass_count_r;
      fail_nx_s    = fail_count_r;
      ff_idx_nx_s  = ff_idx_r;
      ff_pc_nx_s   = ff_pc_r;
      ff_data_nx_s = ff_data_r;
      case (state_r)
         IDLE, DONE, TMO: begin
            if (start) begin
               n_nx_s       = n_clamp_s;
               idx_nx_s     = CW'(0);
               timer_nx_s   = TW'(0);
               pass_nx_s    = CW'(0);
               fail_nx_s    = CW'(0);
               ff_idx_nx_s  = CW'(0);
               ff_pc_nx_s   = PC_W'(0);
               ff_data_nx_s = DATA_W'(0);
               if (n_clamp_s == CW'(0)) begin
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = RUN;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         RUN: begin
            // A qualifying retire wins over an expiring timer in the same cycle.
            if (qual_s) begin
               idx_nx_s   = idx_r + CW'(1);
               timer_nx_s = TW'(0);
               if (match_s) begin
                  pass_nx_s = pass_count_r + CW'(1);
               end else begin
                  fail_nx_s = fail_count_r + CW'(1);
                  if (fail_count_r == CW'(0)) begin
                     ff_idx_nx_s  = idx_r;
                     ff_pc_nx_s   = retire_pc;
                     ff_data_nx_s = retire_data;
                  end else begin
                     ff_idx_nx_s  = ff_idx_r;
                  end
               end
               if (idx_r == last_idx_s) begin
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = RUN;
               end
            end else if (timer_r == TMO_LIM) begin
               state_nx_s = TMO;
            end else begin
               timer_nx_s = timer_r + TW'(1);
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State, run counters, capture and registered status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= IDLE;
         n_r          <= CW'(0);
         idx_r        <= CW'(0);
         timer_r      <= TW'(0);
         pass_count_r <= CW'(0);
         fail_count_r <= CW'(0);
         ff_idx_r     <= CW'(0);
         ff_pc_r      <= PC_W'(0);
         ff_data_r    <= DATA_W'(0);
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         n_r          <= n_nx_s;
         idx_r        <= idx_nx_s;
         timer_r      <= timer_nx_s;
         pass_count_r <= pass_nx_s;
         fail_count_r <= fail_nx_s;
         ff_idx_r     <= ff_idx_nx_s;
         ff_pc_r      <= ff_pc_nx_s;
         ff_data_r    <= ff_data_nx_s;
         busy_r       <= (state_nx_s == RUN);
         done_r       <= (state_nx_s == DONE);
         timeout_r    <= (state_nx_s == TMO);
      end
   end

   assign busy            = busy_r;
   assign done            = done_r;
   assign timeout         = timeout_r;
   assign pass_count      = pass_count_r;
   assign fail_count      = fail_count_r;
   assign first_fail_idx  = ff_idx_r;
   assign first_fail_pc   = ff_pc_r;
   assign first_fail_data = ff_data_r;

endmodule

// File: tb/tb_mips_retire_checker.sv
// Self-checking bench for mips_retire_checker (DEPTH=8, TO_CYCLES=8).
// Expected status is predicted from a trace-level model when a retire or start
// is driven, queued, and compared once the DUT has registered the result.
module tb_mips_retire_checker;

   localparam int DEPTH = 8;
   localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_TMO = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_we = 1'b0;
   logic [2:0]  load_addr = 3'd0;
   logic [4:0]  load_dest = 5'd0;
   logic [31:0] load_data = 32'd0;
   logic        start = 1'b0;
   logic [3:0]  n_checks = 4'd0;
   logic        retire_valid = 1'b0;
   logic [4:0]  retire_dest = 5'd0;
   logic [31:0] retire_data = 32'd0;
   logic [31:0] retire_pc = 32'd0;
   logic        busy, done, timeout;
   logic [3:0]  pass_count, fail_count, first_fail_idx;
   logic [31:0] first_fail_pc, first_fail_data;

   mips_retire_checker #(
      .DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .TO_CYCLES(8), .SKIP_ZERO_DEST(1'b1)
   ) dut (
      .clock(clock), .reset(reset),
      .load_we(load_we), .load_addr(load_addr), .load_dest(load_dest), .load_data(load_data),
      .start(start), .n_checks(n_checks),
      .retire_valid(retire_valid), .retire_dest(retire_dest),
      .retire_data(retire_data), .retire_pc(retire_pc),
      .busy(busy), .done(done), .timeout(timeout),
      .pass_count(pass_count), .fail_count(fail_count),
      .first_fail_idx(first_fail_idx), .first_fail_pc(first_fail_pc),
      .first_fail_data(first_fail_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t  sb[$];
   int    chk_cnt = 0;
   int    err_cnt = 0;
   string cur_tag = "init";

   // reference model state
   int          m_state = S_IDLE;
   int          m_n = 0, m_idx = 0, m_pass = 0, m_fail = 0, m_ff_idx = 0;
   logic [31:0] m_ff_pc = 32'd0, m_ff_data = 32'd0;
   logic [4:0]  m_dest [DEPTH];
   logic [31:0] m_data [DEPTH];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic b, input logic d, input logic t,
                                        input logic [7:0] p, input logic [7:0] f);
      return {45'd0, b, d, t, p, f};
   endfunction

   function automatic logic [63:0] dut_status();
      return pack(busy, done, timeout, 8'(pass_count), 8'(fail_count));
   endfunction

   function automatic logic [63:0] model_status();
      return pack(m_state == S_RUN, m_state == S_DONE, m_state == S_TMO, 8'(m_pass), 8'(m_fail));
   endfunction

   // Advance the trace-level model by one cycle of the currently driven inputs.
   task automatic model_update();
      if (reset) begin
         m_state = S_IDLE; m_n = 0; m_idx = 0; m_pass = 0; m_fail = 0;
         m_ff_idx = 0; m_ff_pc = 32'd0; m_ff_data = 32'd0;
      end else begin
         if (load_we && m_state == S_IDLE) begin
            m_dest[load_addr] = load_dest;
            m_data[load_addr] = load_data;
         end
         if (start && m_state != S_RUN) begin
            m_n = (int'(n_checks) > DEPTH) ? DEPTH : int'(n_checks);
            m_idx = 0; m_pass = 0; m_fail = 0;
            m_ff_idx = 0; m_ff_pc = 32'd0; m_ff_data = 32'd0;
            m_state = (m_n == 0) ? S_DONE : S_RUN;
         end else if (m_state == S_RUN && retire_valid && retire_dest != 5'd0) begin
            if (m_dest[m_idx] == retire_dest && m_data[m_idx] == retire_data) begin
               m_pass++;
            end else begin
               if (m_fail == 0) begin
                  m_ff_idx = m_idx; m_ff_pc = retire_pc; m_ff_data = retire_data;
               end
               m_fail++;
            end
            if (m_idx == m_n - 1) m_state = S_DONE;
            m_idx++;
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      bit   push;
      push = (retire_valid || start) && !reset;
      model_update();
      if (push) begin
         e.tag = cur_tag;
         e.val = model_status();
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, dut_status(), e.val);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(input logic [2:0] a, input logic [4:0] d, input logic [31:0] v);
      load_we = 1'b1; load_addr = a; load_dest = d; load_data = v;
      tick();
      load_we = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] n);
      start = 1'b1; n_checks = n;
      tick();
      start = 1'b0;
   endtask

   task automatic retire(input logic [4:0] d, input logic [31:0] v, input logic [31:0] pc);
      retire_valid = 1'b1; retire_dest = d; retire_data = v; retire_pc = pc;
      tick();
      retire_valid = 1'b0;
   endtask

   task automatic check_capture(input string tag, input int idx, input logic [31:0] pc,
                                input logic [31:0] data);
      check_val({tag, "_idx"}, 64'(first_fail_idx), 64'(idx));
      check_val({tag, "_pc"}, 64'(first_fail_pc), 64'(pc));
      check_val({tag, "_data"}, 64'(first_fail_data), 64'(data));
   endtask

   task automatic retire_good4(input logic [31:0] pc0);
      retire(5'd1, 32'd5, pc0);
      retire(5'd2, 32'hA, pc0 + 32'd4);
      retire(5'd3, 32'hF, pc0 + 32'd8);
      retire(5'd4, 32'hFFFF_FFFF, pc0 + 32'd12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      cur_tag = "reset";
      idle(2);
      reset = 1'b0;
      check_val("reset_status", dut_status(), pack(1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      check_capture("reset_ff", 0, 32'd0, 32'd0);

      // trace table: four reference entries plus four more for the clamp run
      load(3'd0, 5'd1, 32'd5);
      load(3'd1, 5'd2, 32'hA);
      load(3'd2, 5'd3, 32'hF);
      load(3'd3, 5'd4, 32'hFFFF_FFFF);
      load(3'd4, 5'd5, 32'h50);
      load(3'd5, 5'd6, 32'h60);
      load(3'd6, 5'd7, 32'h70);
      load(3'd7, 5'd8, 32'h80);

      // all four match
      cur_tag = "all_pass";
      do_start(4'd4);
      retire_good4(32'h100);
      check_val("all_pass_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd4, 8'd0));

      // one data mismatch at idx 1
      cur_tag = "one_fail";
      do_start(4'd4);
      retire(5'd1, 32'd5, 32'h200);
      retire(5'd2, 32'hB, 32'd1);
      retire(5'd3, 32'hF, 32'h208);
      retire(5'd4, 32'hFFFF_FFFF, 32'h20C);
      check_val("one_fail_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd3, 8'd1));
      check_capture("one_fail_ff", 1, 32'd1, 32'hB);

      // two mismatches: only the first is captured
      cur_tag = "two_fail";
      do_start(4'd4);
      retire(5'd1, 32'd6, 32'h30);
      retire(5'd2, 32'hA, 32'h34);
      retire(5'd9, 32'hF, 32'h38);
      retire(5'd4, 32'hFFFF_FFFF, 32'h3C);
      check_val("two_fail_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd2, 8'd2));
      check_capture("two_fail_ff", 0, 32'h30, 32'd6);

      // branch / SW retires with dest 0 are ignored
      cur_tag = "skip_zero";
      do_start(4'd4);
      retire(5'd1, 32'd5, 32'h400);
      retire(5'd0, 32'h1234, 32'h404);
      retire(5'd2, 32'hA, 32'h408);
      retire(5'd0, 32'hDEAD, 32'h40C);
      retire(5'd3, 32'hF, 32'h410);
      retire(5'd4, 32'hFFFF_FFFF, 32'h414);
      check_val("skip_zero_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd4, 8'd0));

      // timeout eight cycles after the last qualifying retire
      cur_tag = "tmo";
      do_start(4'd2);
      retire(5'd1, 32'd5, 32'h500);
      idle(7);
      check_val("tmo_before_limit", dut_status(), pack(1'b1, 1'b0, 1'b0, 8'd1, 8'd0));
      idle(1);
      check_val("tmo_at_limit", dut_status(), pack(1'b0, 1'b0, 1'b1, 8'd1, 8'd0));
      m_state = S_TMO;
      retire(5'd2, 32'hA, 32'h504);

      // retire exactly on the limit cycle wins over the timeout
      cur_tag = "tmo_race";
      do_start(4'd2);
      retire(5'd1, 32'd5, 32'h600);
      idle(7);
      retire(5'd2, 32'hA, 32'h604);
      check_val("tmo_race_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd2, 8'd0));

      // reset mid-run, then rerun from the persisting table
      cur_tag = "mid_reset";
      do_start(4'd4);
      retire(5'd1, 32'd5, 32'h700);
      retire(5'd2, 32'hA, 32'h704);
      check_val("mid_reset_pre", dut_status(), pack(1'b1, 1'b0, 1'b0, 8'd2, 8'd0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("mid_reset_status", dut_status(), pack(1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      check_capture("mid_reset_ff", 0, 32'd0, 32'd0);
      cur_tag = "rerun";
      do_start(4'd4);
      retire_good4(32'h800);
      check_val("rerun_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd4, 8'd0));

      // n=0 goes straight to DONE; a load during RUN leaves the table alone
      cur_tag = "n_zero";
      do_start(4'd0);
      check_val("n_zero_status", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
      cur_tag = "load_in_run";
      do_start(4'd1);
      load(3'd0, 5'd7, 32'h77);
      retire(5'd1, 32'd5, 32'h900);
      check_val("load_in_run_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd1, 8'd0));

      // n above DEPTH clamps to DEPTH; a start during RUN is ignored
      cur_tag = "clamp";
      do_start(4'd15);
      retire(5'd1, 32'd5, 32'hA00);
      retire(5'd2, 32'hA, 32'hA04);
      cur_tag = "start_in_run";
      do_start(4'd1);
      cur_tag = "clamp";
      retire(5'd3, 32'hF, 32'hA08);
      retire(5'd4, 32'hFFFF_FFFF, 32'hA0C);
      retire(5'd5, 32'h50, 32'hA10);
      retire(5'd6, 32'h60, 32'hA14);
      retire(5'd7, 32'h70, 32'hA18);
      check_val("clamp_seven", dut_status(), pack(1'b1, 1'b0, 1'b0, 8'd7, 8'd0));
      retire(5'd8, 32'h80, 32'hA1C);
      check_val("clamp_final", dut_status(), pack(1'b0, 1'b1, 1'b0, 8'd8, 8'd0));

      check_val("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
